// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator entry sequencer.
// The state encodings are visible on state_code, so their values are fixed.
package calc_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    WAIT_OP1    = 3'd0,
    WAIT_OP2    = 3'd1,
    WAIT_OPCODE = 3'd2,
    COMPUTE     = 3'd3,
    SHOW_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/calc_input_sequencer_if.sv
// Button-pulse inputs and register-bank strobes of the calculator sequencer.
// master = debouncer/register-bank side, slave = the sequencer itself.
interface calc_input_sequencer_if;
  logic       enter;
  logic       undo;
  logic       load_op1;
  logic       load_op2;
  logic       load_opcode;
  logic       load_result;
  logic       clear_op1;
  logic       clear_op2;
  logic       clear_opcode;
  logic       clear_result;
  logic [2:0] state_code;
  logic       busy;
  logic       result_valid;

  modport master (
    output enter, undo,
    input  load_op1, load_op2, load_opcode, load_result,
    input  clear_op1, clear_op2, clear_opcode, clear_result,
    input  state_code, busy, result_valid
  );

  modport slave (
    input  enter, undo,
    output load_op1, load_op2, load_opcode, load_result,
    output clear_op1, clear_op2, clear_opcode, clear_result,
    output state_code, busy, result_valid
  );
endinterface

// File: rtl/latency_down_counter.sv
// Loadable down counter that saturates at zero; zero flag is combinational
// from the registered count.
module latency_down_counter
  import calc_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/calc_input_sequencer.sv
// Entry sequencer for a two-operand calculation: turns enter/undo pulses into
// per-register load/clear strobes and times the ALU result capture.
module calc_input_sequencer
  import calc_seq_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  calc_input_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  // Strobe index: 0 = op1, 1 = op2, 2 = opcode, 3 = result.
  logic [3:0] ld;
  logic [3:0] clr;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  latency_down_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_OP1;
    end else begin
      state_q <= state_d;
    end
  end

  // undo is tested first everywhere so that it wins over a simultaneous enter.
  always_comb begin
    state_d  = state_q;
    ld       = '0;
    clr      = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      WAIT_OP1: begin
        if (bus.undo) begin
          clr[0] = 1'b1;
        end else if (bus.enter) begin
          ld[0]   = 1'b1;
          state_d = WAIT_OP2;
        end
      end
      WAIT_OP2: begin
        if (bus.undo) begin
          clr[0]  = 1'b1;
          state_d = WAIT_OP1;
        end else if (bus.enter) begin
          ld[1]   = 1'b1;
          state_d = WAIT_OPCODE;
        end
      end
      WAIT_OPCODE: begin
        if (bus.undo) begin
          clr[1]  = 1'b1;
          state_d = WAIT_OP2;
        end else if (bus.enter) begin
          ld[2]    = 1'b1;
          cnt_load = 1'b1;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_zero) begin
          ld[3]   = 1'b1;
          state_d = SHOW_RESULT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SHOW_RESULT: begin
        if (bus.undo) begin
          clr[3]  = 1'b1;
          clr[2]  = 1'b1;
          state_d = WAIT_OPCODE;
        end else if (bus.enter) begin
          clr     = '1;
          state_d = WAIT_OP1;
        end
      end
      default: begin
        clr     = '1;
        state_d = WAIT_OP1;
      end
    endcase
  end

  // Strobes are Mealy and would otherwise follow enter/undo during reset.
  assign bus.load_op1     = ld[0]  & ~rst;
  assign bus.load_op2     = ld[1]  & ~rst;
  assign bus.load_opcode  = ld[2]  & ~rst;
  assign bus.load_result  = ld[3]  & ~rst;
  assign bus.clear_op1    = clr[0] & ~rst;
  assign bus.clear_op2    = clr[1] & ~rst;
  assign bus.clear_opcode = clr[2] & ~rst;
  assign bus.clear_result = clr[3] & ~rst;

  assign bus.state_code   = 3'(state_q);
  assign bus.busy         = (state_q == COMPUTE);
  assign bus.result_valid = (state_q == SHOW_RESULT);

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: two instances (ALU_LAT=2 and 1) share one
// enter/undo stimulus and are compared every cycle against a phase model.
module tb_calc_input_sequencer;
  import calc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enter_s = 1'b0;
  logic undo_s = 1'b0;
  logic forced = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  calc_input_sequencer_if ifa ();
  calc_input_sequencer_if ifb ();

  assign ifa.enter = enter_s;
  assign ifa.undo  = undo_s;
  assign ifb.enter = enter_s;
  assign ifb.undo  = undo_s;

  calc_input_sequencer #(.ALU_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  calc_input_sequencer #(.ALU_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // {ld_op1, ld_op2, ld_opcode, ld_result, clr_op1, clr_op2, clr_opcode, clr_result}
  logic [7:0] sa, sb;
  assign sa = {ifa.load_op1, ifa.load_op2, ifa.load_opcode, ifa.load_result,
               ifa.clear_op1, ifa.clear_op2, ifa.clear_opcode, ifa.clear_result};
  assign sb = {ifb.load_op1, ifb.load_op2, ifb.load_opcode, ifb.load_result,
               ifb.clear_op1, ifb.clear_op2, ifb.clear_opcode, ifb.clear_result};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase = number of completed entries (0..4), result due at an absolute cycle.
  int ph [2];
  int due [2];
  int cyc_n = 0;

  always @(negedge clk) begin : compare
    logic [7:0]  es;
    logic [12:0] act;
    logic [12:0] expv;
    int          np;
    int          scx;
    int          lat;
    cyc_n++;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 2 : 1;
      es  = 8'h00;
      np  = ph[i];
      scx = ph[i];
      if (rst) begin
        np  = 0;
        scx = 0;
      end else if (i == 0 && forced) begin
        es  = 8'h0F;
        np  = 0;
        scx = 6;
      end else begin
        case (ph[i])
          0: if (undo_s) es = 8'h08;
             else if (enter_s) begin es = 8'h80; np = 1; end
          1: if (undo_s) begin es = 8'h08; np = 0; end
             else if (enter_s) begin es = 8'h40; np = 2; end
          2: if (undo_s) begin es = 8'h04; np = 1; end
             else if (enter_s) begin es = 8'h20; np = 3; due[i] = cyc_n + lat; end
          3: if (cyc_n == due[i]) begin es = 8'h10; np = 4; end
          default: if (undo_s) begin es = 8'h03; np = 2; end
                   else if (enter_s) begin es = 8'h0F; np = 0; end
        endcase
      end
      expv = {es, 3'(scx), scx == 3, scx == 4};
      if (i == 0) act = {sa, ifa.state_code, ifa.busy, ifa.result_valid};
      else        act = {sb, ifb.state_code, ifb.busy, ifb.result_valid};
      chk((i == 0) ? "model_lat2" : "model_lat1", 32'(act), 32'(expv));
      ph[i] = np;
    end
  end

  task automatic step(input logic e, input logic u);
    @(posedge clk);
    #1;
    enter_s = e;
    undo_s  = u;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    enter_s = 1'b0;
    undo_s  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ph[0] = 0; ph[1] = 0; due[0] = 0; due[1] = 0;
    #1 rst = 1'b1;
    #2;
    chk("reset_state_code", 32'(ifa.state_code), 32'd0);
    chk("reset_flags", 32'({ifa.busy, ifa.result_valid}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Enter pulses on cycles 2, 5, 8.
    step(0, 0); step(0, 0);
    step(1, 0); chk("c2_load_op1", 32'(sa), 32'h80);
    step(0, 0); step(0, 0);
    step(1, 0); chk("c5_load_op2", 32'(sa), 32'h40);
    step(0, 0); step(0, 0);
    step(1, 0); chk("c8_load_opcode", 32'(sa), 32'h20);
    chk("c8_load_opcode_b", 32'(sb), 32'h20);
    step(0, 0); chk("c9_busy", 32'(ifa.busy), 32'd1);
    chk("c9_no_result", 32'(sa), 32'h00);
    chk("lat1_result_k1", 32'(sb), 32'h10);
    chk("lat1_busy_k1", 32'(ifb.busy), 32'd1);
    step(0, 0); chk("c10_load_result", 32'(sa), 32'h10);
    chk("c10_busy", 32'(ifa.busy), 32'd1);
    chk("lat1_show_k2", 32'(ifb.state_code), 32'd4);
    step(0, 0); chk("c11_result_valid", 32'(ifa.result_valid), 32'd1);

    // Undo chain from SHOW_RESULT.
    step(0, 1); chk("undo1_strobes", 32'(sa), 32'h03);
    step(0, 1); chk("undo2_strobes", 32'(sa), 32'h04);
    chk("undo2_state", 32'(ifa.state_code), 32'd2);
    step(0, 1); chk("undo3_strobes", 32'(sa), 32'h08);
    chk("undo3_state", 32'(ifa.state_code), 32'd1);
    step(0, 0); chk("undo_done_state", 32'(ifa.state_code), 32'd0);

    // enter+undo together in WAIT_OPCODE.
    step(1, 0); step(1, 0);
    step(1, 1); chk("both_strobes", 32'(sa), 32'h04);
    step(0, 0); chk("both_state", 32'(ifa.state_code), 32'd1);

    // Pulses during COMPUTE must not disturb result timing.
    step(1, 0);
    step(1, 0); chk("k_load_opcode", 32'(sa), 32'h20);
    step(1, 0); chk("compute_enter_ignored", 32'(sa), 32'h00);
    step(0, 1); chk("compute_undo_result", 32'(sa), 32'h10);
    step(0, 0); chk("compute_then_show", 32'(ifa.result_valid), 32'd1);

    // Reset in the middle of COMPUTE.
    do_reset();
    step(1, 0); step(1, 0); step(1, 0);
    step(0, 0);
    @(posedge clk);
    #1;
    enter_s = 1'b1;
    rst     = 1'b1;
    #1;
    chk("rst_strobes_a", 32'(sa), 32'h00);
    chk("rst_strobes_b", 32'(sb), 32'h00);
    chk("rst_state_busy", 32'({ifa.state_code, ifa.busy}), 32'd0);
    @(posedge clk);
    #1;
    enter_s = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      chk("post_rst_no_result", 32'({sa, ifa.state_code}), 32'd0);
    end

    // Illegal state encoding recovers with all clears.
    step(0, 0);
    force dut_a.state_q = state_t'(3'd6);
    forced = 1'b1;
    #1;
    chk("illegal_clears", 32'(sa), 32'h0F);
    @(negedge clk);
    #1;
    release dut_a.state_q;
    forced = 1'b0;
    step(0, 0);
    chk("illegal_recovered", 32'({sa, ifa.state_code}), 32'd0);

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      #1;
      enter_s = ($urandom_range(0, 2) == 0);
      undo_s  = ($urandom_range(0, 5) == 0);
      rst     = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk);
    #1;
    enter_s = 1'b0;
    undo_s  = 1'b0;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
